// File: rtl/frame_threshold_engine.sv
// frame_threshold_engine
//   Per-frame gray histogram, frame-end cumulative sweep to find the percentile
//   bin, and a fixed-latency pixel path that binarises/masks against the
//   threshold found on the previous frame.
//   Optional feature: define THRESH_SMOOTH_EN to blend each new threshold into
//   the previous one with a rounded first-order IIR instead of replacing it.
module frame_threshold_engine #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 20,
  parameter int LAT   = 2
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iFval,
  input  logic [PIX_W-1:0] iGray,
  input  logic             iGrayValid,
  input  logic [7:0]       iPercent,
  input  logic [1:0]       iMode,
  output logic [PIX_W-1:0] oPixel,
  output logic             oValid,
  output logic [PIX_W-1:0] oThresh,
  output logic             oThreshVal,
  output logic             oBusy,
  output logic             oOverrun
);

  localparam int BINS = 1 << PIX_W;
  localparam int CW   = CNT_W + PIX_W;  // cumulative sum cannot wrap even with saturated bins

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SWEEP} state_e;

  state_e             state_q;
  logic               init_q;      // current/pending sweep is the reset-time clear
  logic               fval_q;
  logic               a_v_q;       // RMW stage: increment pending for a_bin_q
  logic [PIX_W-1:0]   a_bin_q;
  logic [CNT_W-1:0]   a_rd_q;
  logic [CNT_W-1:0]   pix_cnt_q;
  logic [CNT_W-1:0]   target_q;
  logic [PIX_W-1:0]   idx_q;
  logic [CW-1:0]      cum_q;
  logic               found_q;
  logic [PIX_W-1:0]   thr_new_q;
  logic [PIX_W-1:0]   thresh_q;
  logic               thr_val_q;
  logic               busy_q;
  logic               overrun_q;

  logic [CNT_W-1:0]   hist_q [BINS];
  logic [PIX_W-1:0]   pix_pipe_q [LAT];
  logic [LAT-1:0]     vld_pipe_q;

  logic               fval_rise, fval_fall, count_en, hit;
  logic [CNT_W-1:0]   inc_val, bin_rd, target_w;
  logic [CNT_W+7:0]   prod_w;
  logic [CW-1:0]      cum_d;
  logic [PIX_W-1:0]   thr_pick, thr_upd, pix_proc;

  assign fval_rise = iFval & ~fval_q;
  assign fval_fall = ~iFval & fval_q;
  // Pixels coincident with the frame-start edge belong to the new frame.
  assign count_en  = iGrayValid & iFval &
                     ((state_q == S_ACCUM) | ((state_q == S_IDLE) & ~init_q & fval_rise));
  assign inc_val   = (a_rd_q == '1) ? a_rd_q : a_rd_q + 1'b1;
  assign prod_w    = (CNT_W + 8)'(pix_cnt_q) * (CNT_W + 8)'(iPercent);
  assign target_w  = CNT_W'(prod_w >> 8);
  assign bin_rd    = hist_q[idx_q];
  assign cum_d     = cum_q + CW'(bin_rd);
  assign hit       = (cum_d >= CW'(target_q));

`ifdef THRESH_SMOOTH_EN
  logic [PIX_W:0] smooth_sum;
  assign smooth_sum = {1'b0, thresh_q} + {1'b0, thr_pick} + (PIX_W + 1)'(1);
`endif

  // Pick the sweep result and form the next threshold value.
  // NOTE: every always_comb output gets a default/full assignment first, so no latch is inferred.
  always_comb begin
    thr_pick = found_q ? thr_new_q : (hit ? idx_q : '1);
`ifdef THRESH_SMOOTH_EN
    thr_upd  = smooth_sum[PIX_W:1];
`else
    thr_upd  = thr_pick;
`endif
  end

  // Per-pixel transform using the threshold present when the pixel enters.
  always_comb begin
    pix_proc = iGray;
    case (iMode)
      2'd1:    pix_proc = (iGray >= thresh_q) ? '1 : '0;
      2'd2:    pix_proc = (iGray >= thresh_q) ? '0 : '1;
      2'd3:    pix_proc = (iGray >= thresh_q) ? iGray : '0;
      default: pix_proc = iGray;
    endcase
  end

  // Control FSM, histogram RMW front stage, pixel count and sweep datapath.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= S_IDLE;
      init_q    <= 1'b1;
      fval_q    <= 1'b0;
      a_v_q     <= 1'b0;
      a_bin_q   <= '0;
      a_rd_q    <= '0;
      pix_cnt_q <= '0;
      target_q  <= '0;
      idx_q     <= '0;
      cum_q     <= '0;
      found_q   <= 1'b0;
      thr_new_q <= '0;
      thresh_q  <= {1'b1, {(PIX_W-1){1'b0}}};
      thr_val_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      fval_q    <= iFval;
      thr_val_q <= 1'b0;
      a_v_q     <= count_en;
      if (count_en) begin
        a_bin_q <= iGray;
        // Forward the in-flight write when the same bin arrives back-to-back.
        a_rd_q  <= (a_v_q && a_bin_q == iGray) ? inc_val : hist_q[iGray];
        if (pix_cnt_q != '1) pix_cnt_q <= pix_cnt_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (init_q) begin
            state_q <= S_SWEEP;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            cum_q   <= '0;
            found_q <= 1'b0;
          end else if (fval_rise) begin
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (fval_fall) begin
            state_q   <= S_SWEEP;
            busy_q    <= 1'b1;
            target_q  <= target_w;
            pix_cnt_q <= '0;
            idx_q     <= '0;
            cum_q     <= '0;
            found_q   <= 1'b0;
          end
        end
        S_SWEEP: begin
          if (fval_rise && !init_q) overrun_q <= 1'b1;
          cum_q <= cum_d;
          idx_q <= idx_q + 1'b1;
          if (!found_q && hit) begin
            found_q   <= 1'b1;
            thr_new_q <= idx_q;
          end
          if (idx_q == '1) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (init_q) begin
              init_q <= 1'b0;
            end else begin
              thresh_q  <= thr_upd;
              thr_val_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Histogram storage: sweep clears bin idx_q, otherwise the RMW back stage writes.
  // NOTE: the bin array has no reset branch; it is cleared by the reset-time sweep instead.
  always_ff @(posedge iClk) begin
    if (state_q == S_SWEEP) begin
      hist_q[idx_q] <= '0;
    end else if (a_v_q) begin
      hist_q[a_bin_q] <= inc_val;
    end
  end

  // Fixed-latency pixel delay line, running in every state.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < LAT; i++) pix_pipe_q[i] <= '0;
      vld_pipe_q <= '0;
    end else begin
      pix_pipe_q[0] <= pix_proc;
      vld_pipe_q[0] <= iGrayValid;
      for (int i = 1; i < LAT; i++) begin
        pix_pipe_q[i] <= pix_pipe_q[i-1];
        vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end
  end

  assign oPixel     = pix_pipe_q[LAT-1];
  assign oValid     = vld_pipe_q[LAT-1];
  assign oThresh    = thresh_q;
  assign oThreshVal = thr_val_q;
  assign oBusy      = busy_q;
  assign oOverrun   = overrun_q;

endmodule
